serial_rx: RTL

- 8N1 UART receiver with 16x oversampling; the receive-side counterpart of the team's Serial transmitter. Bit timing is identical to Serial.
- Collects BUFFLEN bytes into a flat buffer in Serial's byte and bit order, then raises DONE and holds the buffer until ACK.
- Sits between the board RXD pin and logic that loads ciphertext or password candidates, such as the Decoder's ENCRYPTED operand.

---
 rtl/serial_rx_pkg.sv | 30 +++
 rtl/serial_rx_if.sv | 29 ++
 rtl/serial_rx_tick.sv | 43 ++++
 rtl/serial_rx.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
//------------------------------------------------------------------------------
// serial_rx_pkg
// Shared types and constants for the serial_rx UART receiver.
//   state_t      : receiver FSM states (IDLE, START, DATA, STOP)
//   SAMPLE_PHASE : oversample phase at the middle of a bit
//   OVERSAMPLE   : ticks per bit
//   ERR_FRAME / ERR_OVR : bit positions inside the ERR flag vector
//   maj3()       : 2-of-3 vote used by the optional majority sampler
//------------------------------------------------------------------------------
package serial_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int SAMPLE_PHASE = 7;
    localparam int OVERSAMPLE   = 16;
    localparam int PHASE_W      = $clog2(OVERSAMPLE);

    localparam int ERR_FRAME = 0;
    localparam int ERR_OVR   = 1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/serial_rx_if.sv
//------------------------------------------------------------------------------
// serial_rx_if
// Consumer-side bundle of the serial_rx receiver.
//   ACK    : consumer releases a completed buffer
//   DONE   : buffer holds BUFFLEN valid bytes
//   ERR    : sticky flags, [ERR_FRAME] framing, [ERR_OVR] overrun
//   COUNT  : bytes stored in the current transfer
//   BUFFER : received bytes, byte k at [8k:8k+7], bit 0 at [8k+7]
// Modports: master = receiver, slave = consumer.
//------------------------------------------------------------------------------
interface serial_rx_if #(
    parameter int BUFFLEN = 5
);
    logic                   ACK;
    logic                   DONE;
    logic [1:0]             ERR;
    logic [7:0]             COUNT;
    logic [0:8*BUFFLEN-1]   BUFFER;

    modport master (
        input  ACK,
        output DONE, ERR, COUNT, BUFFER
    );

    modport slave (
        output ACK,
        input  DONE, ERR, COUNT, BUFFER
    );
endinterface

// File: rtl/serial_rx_tick.sv
//------------------------------------------------------------------------------
// serial_rx_tick
// Oversample divider: tick pulses once every CLOCK+1 cycles, phase counts
// ticks modulo 16 so one full phase turn is one bit time.
//   CLK   : clock
//   RESET : synchronous, active-high reset
//   clr   : synchronous restart of divider and phase (start-edge alignment)
//   tick  : one-cycle strobe, high while the divider sits at CLOCK
//   phase : position inside the current bit, 0..15
//------------------------------------------------------------------------------
module serial_rx_tick
    import serial_rx_pkg::*;
#(
    parameter int CLOCK = 26
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               clr,
    output logic               tick,
    output logic [PHASE_W-1:0] phase
);

    localparam int CNT_W = (CLOCK < 1) ? 1 : $clog2(CLOCK + 1);

    logic [CNT_W-1:0] slckcount;

    assign tick = (slckcount == CNT_W'(CLOCK));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RESET || clr) begin
            slckcount <= '0;
            phase     <= '0;
        end else if (tick) begin
            slckcount <= '0;
            phase     <= phase + 1'b1;
        end else begin
            slckcount <= slckcount + 1'b1;
        end
    end

endmodule

// File: rtl/serial_rx.sv
//------------------------------------------------------------------------------
// serial_rx
// 8N1 UART receiver, 16x oversampling, bit timing matching the Serial
// transmitter. Collects BUFFLEN bytes into bus.BUFFER, raises DONE and holds
// the buffer until the consumer pulses ACK.
//   CLK   : clock
//   RESET : synchronous, active-high reset
//   RXD   : asynchronous serial line, idle high
//   bus   : serial_rx_if.master (ACK in; DONE, ERR, COUNT, BUFFER out)
// Build option: define SERIAL_RX_MAJORITY_EN to vote each bit 2-of-3 over
// the phase 6/7/8 ticks and decide at phase 8 instead of sampling once at 7.
//------------------------------------------------------------------------------
module serial_rx
    import serial_rx_pkg::*;
#(
    parameter int BUFFLEN = 5,
    parameter int CLOCK   = 26
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         RXD,
    serial_rx_if.master  bus
);

    logic               rx_meta, rx_s, rx_prev;
    logic [1:0]         sync_vld;
    logic               line_edge;
    logic               tick, tick_clr;
    logic [PHASE_W-1:0] phase;
    logic               decide, bit_val;
    logic               start_ok, shift_en, byte_end;
    logic [2:0]         bitcnt;
    logic [7:0]         shift;
    state_t             state, state_next;

    serial_rx_tick #(.CLOCK(CLOCK)) u_tick (
        .CLK   (CLK),
        .RESET (RESET),
        .clr   (tick_clr),
        .tick  (tick),
        .phase (phase)
    );

    // Two-flop synchronizer. sync_vld marks when rx_s carries real line data
    // rather than its reset value, so a line held low through reset never
    // looks like a falling edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_prev  <= 1'b0;
            sync_vld <= 2'b00;
        end else begin
            rx_meta  <= RXD;
            rx_s     <= rx_meta;
            rx_prev  <= sync_vld[1] ? rx_s : 1'b0;
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

    assign line_edge = sync_vld[1] & rx_prev & ~rx_s;

`ifdef SERIAL_RX_MAJORITY_EN
    logic samp_a, samp_b;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else if (tick) begin
            if (phase == PHASE_W'(SAMPLE_PHASE - 1)) samp_a <= rx_s;
            if (phase == PHASE_W'(SAMPLE_PHASE))     samp_b <= rx_s;
        end
    end

    assign decide  = tick && (phase == PHASE_W'(SAMPLE_PHASE + 1));
    assign bit_val = maj3(samp_a, samp_b, rx_s);
`else
    assign decide  = tick && (phase == PHASE_W'(SAMPLE_PHASE));
    assign bit_val = rx_s;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        tick_clr   = 1'b0;
        start_ok   = 1'b0;
        shift_en   = 1'b0;
        byte_end   = 1'b0;
        unique case (state)
            IDLE: begin
                if (line_edge) begin
                    tick_clr   = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                // The phase keeps running from here on, so each later
                // decision tick lands one full bit after the previous one.
                if (decide) begin
                    if (!bit_val) begin
                        start_ok   = 1'b1;
                        state_next = DATA;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (decide) begin
                    shift_en = 1'b1;
                    if (bitcnt == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                // Leave mid stop bit so the next start edge is not missed.
                if (decide) begin
                    byte_end   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bitcnt <= '0;
            shift  <= '0;
        end else if (start_ok) begin
            bitcnt <= '0;
        end else if (shift_en) begin
            shift[bitcnt] <= bit_val;
            bitcnt        <= bitcnt + 1'b1;
        end
    end

    // NOTE: BUFFER is reset even though it behaves like storage, because the
    // consumer can read it at any time and must see zeros after reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            bus.DONE   <= 1'b0;
            bus.ERR    <= '0;
            bus.COUNT  <= '0;
            bus.BUFFER <= '0;
        end else begin
            if (bus.ACK && bus.DONE) begin
                bus.DONE  <= 1'b0;
                bus.COUNT <= '0;
                bus.ERR   <= '0;
            end
            // Stores happen only while DONE=0, so a same-cycle ACK is ignored
            // and the completing byte always lands.
            if (byte_end) begin
                if (!bit_val) begin
                    bus.ERR[ERR_FRAME] <= 1'b1;
                end else if (bus.DONE) begin
                    bus.ERR[ERR_OVR] <= 1'b1;
                end else begin
                    // Byte k occupies [8k:8k+7]; the ascending range puts
                    // data bit 0 at index 8k+7.
                    for (int k = 0; k < BUFFLEN; k++) begin
                        if (bus.COUNT == 8'(k)) bus.BUFFER[8*k +: 8] <= shift;
                    end
                    bus.COUNT <= bus.COUNT + 8'd1;
                    if (bus.COUNT == 8'(BUFFLEN - 1)) bus.DONE <= 1'b1;
                end
            end
        end
    end

endmodule
